// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared definitions for the round-robin 4-way arbiter.
// Includes the state encoding and the rotating priority pick function.
package rr_mux4_arbiter_pkg;

    localparam int REQ_N = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arbState_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Walk offsets from the highest down so the closest one to ptr is the last (winning) write.
    function automatic pick_t pickNext(input logic [REQ_N-1:0] req, input logic [1:0] ptr);
        pick_t      res;
        logic [1:0] cand;
        res = '0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4.sv
// 4:1 width-parameterised mux.
// This is the shared data path steered by the arbiter's select.
module mux4Variable #(
    parameter int WIDTH = 2
) (
    input  logic [1:0]       Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Y
);

    always_comb begin
        Y = A;
        case (Control)
            2'd0: Y = A;
            2'd1: Y = B;
            2'd2: Y = C;
            2'd3: Y = D;
            default: Y = A;
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter with capped sticky grants.
// It drives a shared 4:1 mux so the owner's data appears on Y.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REQ_N-1:0] Req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [REQ_N-1:0] Gnt,
    output logic [1:0]       Sel,
    output logic             Busy,
    output logic [WIDTH-1:0] Y
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arbState_e        state_q;
    logic [REQ_N-1:0] gnt_q;
    logic [1:0]       sel_q;
    logic [1:0]       ptr_q;
    logic [HOLD_W-1:0] hold_q;

    pick_t pick_d;
    logic  keep_d;

    // Ptr already sits past the owner, so re-arbitration naturally favours the others and regrants the owner only when alone.
    always_comb begin
        pick_d = pickNext(Req, ptr_q);
        keep_d = (state_q == OWNED) && Req[sel_q] && (hold_q < HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
        end else if (keep_d) begin
            hold_q <= hold_q + HOLD_W'(1);
        end else if (pick_d.found) begin
            state_q <= OWNED;
            gnt_q   <= 4'b0001 << pick_d.idx;
            sel_q   <= pick_d.idx;
            hold_q  <= '0;
            ptr_q   <= pick_d.idx + 2'd1;
        end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
        end
    end

    assign Gnt  = gnt_q;
    assign Sel  = sel_q;
    assign Busy = (state_q == OWNED);

    mux4Variable #(
        .WIDTH(WIDTH)
    ) uMux (
        .Control(sel_q),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .Y      (Y)
    );

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
Round-robin arbiter that shares one 4:1 width-parameterised mux path between four requesters. Each requester raises a request; the arbiter grants exactly one at a time and drives the mux select so the granted requester's data appears on the shared output. Grants are sticky while the owner keeps requesting, capped by MAX_HOLD cycles, so no requester starves. Sits in front of any shared bus or functional unit that today takes a hard-wired select.

Parameters:
WIDTH, 2, data width of each requester input and of the shared output
MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant (legal range 1..16)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Req  input  4  request per requester, bit i = requester i
A  input  WIDTH  requester 0 data
B  input  WIDTH  requester 1 data
C  input  WIDTH  requester 2 data
D  input  WIDTH  requester 3 data
Gnt  output  4  registered one-hot grant; all-zero when idle
Sel  output  2  registered mux select = index of current owner
Busy  output  1  registered; 1 while any grant is active
Y  output  WIDTH  shared output = data of the requester selected by Sel (combinational from Sel and A..D)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset (reset=1 at a rising edge): Gnt=0000, Sel=00, Busy=0, priority pointer Ptr=0, hold counter Hold=0. Y therefore shows A. Reset overrides all other activity, including a grant in progress.
- State machine: IDLE (Busy=0) and OWNED (Busy=1).
- Pick function: first asserted Req bit searching Ptr, Ptr+1, Ptr+2, Ptr+3 (mod 4).
- IDLE: if Req=0000, stay. Otherwise, at the next edge, move to OWNED with Gnt=onehot(pick), Sel=pick, Hold=0, Ptr=pick+1 mod 4. Latency is one cycle from Req seen to Gnt visible.
- OWNED, owner o: when Req[o]=1 and Hold<MAX_HOLD-1, keep the grant and increment Hold.
- OWNED, release: release occurs when Req[o]=0 or Hold=MAX_HOLD-1. Re-arbitrate in the same edge using Ptr (already o+1).
  - If another requester is pending, grant it directly with no idle bubble and Hold=0.
  - If only o is requesting (hold expiry case), regrant o with Hold=0 and Ptr unchanged.
  - If Req=0000, go to IDLE: Gnt=0000 and Busy=0. Sel keeps its last value.
- MAX_HOLD=1 means the grant rotates every cycle whenever more than one requester is pending.
- Gnt is always one-hot or zero. Sel always equals the index of the set Gnt bit while Busy=1.
- Requests that appear and vanish within a cycle are only seen if present at the edge. Req is sampled, not latched.
- Hold counter width is clog2(MAX_HOLD), minimum 1 bit. It never exceeds MAX_HOLD-1.
- Y is a pure function of Sel. Consumers must qualify Y with Busy/Gnt.

Decomposition:
- Shared package: state encoding (IDLE=0, OWNED=1), the REQ_N=4 constant, and the pick function (rotating priority encoder, 4-bit vector plus 2-bit pointer to 2-bit index plus found flag).
- Sub-module: the team's existing 4:1 width-parameterised mux (mux4Variable), instantiated with WIDTH, Control=Sel, inputs A..D, output Y.
- Arbiter FSM, pointer and hold counter stay in this module.

Test Plan:
- Reset, then Req=0000 for 5 cycles -> Gnt=0000, Busy=0, Sel=00, Y=A throughout.
- Req=0100 at cycle 0, held for 2 cycles then dropped -> Gnt=0100 and Sel=10 at cycles 1-2, Y=C; Gnt=0000 and Busy=0 at cycle 3.
- Req=1111 held, MAX_HOLD=4 -> owners 0,1,2,3,0 each for exactly 4 cycles. Gnt sequence 0001,0010,0100,1000 with no gap cycles.
- Only Req[1]=1 held for 10 cycles, MAX_HOLD=4 -> Gnt=0010 continuously, Hold wraps 0..3, Busy never drops.
- Owner 2 drops Req in the same cycle Req[0] and Req[3] rise (Ptr=3) -> next Gnt=1000 (requester 3), then requester 0 after its release.
- reset asserted mid-grant (Gnt=0100) -> next edge Gnt=0000, Sel=00, Ptr=0. With Req=1111 afterwards, first grant goes to requester 0.
